// File: rtl/sm_dm_arbiter.sv
// Two-master arbiter/sequencer for the schoolMIPS single-port data memory.
// Define SM_DM_ARB_RR_EN for round-robin arbitration (default: master 0 has fixed priority).
module sm_dm_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          owner_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          mem_we_q;
  logic          m0_ack_q;
  logic          m1_ack_q;
  logic          any_req;
  logic          win_d;
  logic          arb_en;

  assign any_req = m0_req | m1_req;
  // Grants are combinational, so they must also be suppressed while reset is held.
  assign arb_en  = (state_q == IDLE) & ~rst & any_req;

`ifdef SM_DM_ARB_RR_EN
  logic last_q;

  always_comb begin
    win_d = 1'b0;
    if (m0_req && m1_req) win_d = ~last_q;
    else                  win_d = ~m0_req;
  end
`else
  always_comb begin
    win_d = ~m0_req;
  end
`endif

  assign m0_gnt = arb_en & ~win_d;
  assign m1_gnt = arb_en &  win_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      mem_we_q <= 1'b0;
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
`ifdef SM_DM_ARB_RR_EN
      last_q   <= 1'b1;
`endif
    end else begin
      mem_we_q <= 1'b0;
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q  <= win_d;
            we_q     <= win_d ? m1_we    : m0_we;
            addr_q   <= win_d ? m1_addr  : m0_addr;
            wdata_q  <= win_d ? m1_wdata : m0_wdata;
            mem_we_q <= win_d ? m1_we    : m0_we;
            cnt_q    <= LAT_M1;
            state_q  <= ACCESS;
`ifdef SM_DM_ARB_RR_EN
            last_q   <= win_d;
`endif
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            rdata_q  <= we_q ? '0 : mem_rdata;
            m0_ack_q <= ~owner_q;
            m1_ack_q <= owner_q;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_rdata  = m0_ack_q ? rdata_q : '0;
  assign m1_rdata  = m1_ack_q ? rdata_q : '0;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = mem_we_q;

  lat_range_a: assert property (@(posedge clk) (LAT >= 1 && LAT <= 15))
    else $error("sm_dm_arbiter: LAT=%0d outside 1..15", LAT);

endmodule
